// File: rtl/fetch_unit_if.sv
// Instruction-memory bus between the fetch unit (master) and instruction memory (slave).
interface fetch_unit_if;
  logic        mem_req;
  logic [31:0] mem_addr;
  logic [31:0] mem_rdata;
  logic        mem_ack;

  modport master (output mem_req, output mem_addr, input mem_rdata, input mem_ack);
  modport slave  (input mem_req, input mem_addr, output mem_rdata, output mem_ack);
endinterface

// File: rtl/fetch_unit.sv
// Instruction fetch FSM: requests a word, presents it for one EXEC cycle, then follows nPc.
// Latency: ack wait cycles + 1 to instr_valid; no ack within TIMEOUT cycles is a sticky fault.
module fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h00000000,
  parameter int          TIMEOUT  = 255
) (
  input  logic              clk,
  input  logic              reset,
  fetch_unit_if.master      mem,
  input  logic [31:0]       nPc,
  input  logic              halt,
  output logic [31:0]       instruction,
  output logic              instr_valid,
  output logic [31:0]       pc_out,
  output logic              fault,
  output logic [1:0]        fault_cause
);

  localparam int CW = ($clog2(TIMEOUT + 1) > 8) ? $clog2(TIMEOUT + 1) : 8;
  localparam logic [CW-1:0] CNT_MAX = '1;
  localparam logic [CW-1:0] TO      = CW'(TIMEOUT);
  localparam logic [31:0]   NOP     = 32'h00000013;

  typedef enum logic [1:0] {FETCH, EXEC, HALTED, FAULT} state_t;

  state_t        state, state_nxt;
  logic [31:0]   pc, pc_nxt;
  logic [31:0]   instr_nxt;
  logic [CW-1:0] wcnt, wcnt_nxt, wcnt_inc;
  logic [1:0]    cause_nxt;

  // Saturating increment so a huge TIMEOUT can never be skipped by wrap-around.
  assign wcnt_inc = (wcnt == CNT_MAX) ? wcnt : wcnt + 1'b1;

  always_comb begin
    state_nxt = state;
    pc_nxt    = pc;
    instr_nxt = instruction;
    wcnt_nxt  = wcnt;
    cause_nxt = fault_cause;
    case (state)
      FETCH: begin
        if (mem.mem_ack) begin
          instr_nxt = mem.mem_rdata;
          wcnt_nxt  = '0;
          state_nxt = EXEC;
        end else begin
          wcnt_nxt = wcnt_inc;
          if (wcnt_inc >= TO) begin
            state_nxt = FAULT;
            cause_nxt = 2'b10;
          end
        end
      end
      EXEC: begin
        // Halt wins over a misaligned target; both leave pc on the presented instruction.
        if (halt) begin
          state_nxt = HALTED;
        end else if (nPc[1:0] != 2'b00) begin
          state_nxt = FAULT;
          cause_nxt = 2'b01;
        end else begin
          pc_nxt    = nPc;
          wcnt_nxt  = '0;
          state_nxt = FETCH;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= FETCH;
      pc          <= RESET_PC;
      instruction <= NOP;
      wcnt        <= '0;
      fault_cause <= 2'b00;
    end else begin
      state       <= state_nxt;
      pc          <= pc_nxt;
      instruction <= instr_nxt;
      wcnt        <= wcnt_nxt;
      fault_cause <= cause_nxt;
    end
  end

  // Strobes are masked during the reset cycle so nothing is requested or committed.
  assign mem.mem_req  = (state == FETCH) && !reset;
  assign mem.mem_addr = {pc[31:2], 2'b00};
  assign instr_valid  = (state == EXEC) && !reset;
  assign pc_out       = pc;
  assign fault        = (state == FAULT);

endmodule

// File: tb/tb_fetch_unit.sv
// Randomized bench for fetch_unit with a transaction-level reference model and per-cycle compare.
module tb_fetch_unit;
  localparam logic [31:0] RESET_PC = 32'h00000000;
  localparam int          TIMEOUT  = 4;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] nPc;
  logic        halt;
  logic [31:0] instruction, pc_out;
  logic        instr_valid, fault;
  logic [1:0]  fault_cause;

  fetch_unit_if bus();

  fetch_unit #(.RESET_PC(RESET_PC), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .reset(reset), .mem(bus), .nPc(nPc), .halt(halt),
    .instruction(instruction), .instr_valid(instr_valid), .pc_out(pc_out),
    .fault(fault), .fault_cause(fault_cause)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;

  // Model: status 0 running, 2 halted, 3 faulted.
  logic [31:0] m_pc, m_instr;
  int          m_status;
  logic [1:0]  m_cause;

  logic        e_req, e_valid, e_fault;
  logic [31:0] e_addr, e_instr, e_pc;
  logic [1:0]  e_cause;
  bit          chk_en = 1'b0;
  int          req_cycles;
  logic [31:0] obs_pc[$];

  function automatic logic [31:0] word(input logic [31:0] a);
    return (a * 32'h9E3779B1) ^ 32'hA5A50F0F;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (chk_en) begin
      check("mem_req", 32'(bus.mem_req), 32'(e_req));
      check("mem_addr", bus.mem_addr, e_addr);
      check("instr_valid", 32'(instr_valid), 32'(e_valid));
      check("instruction", instruction, e_instr);
      check("pc_out", pc_out, e_pc);
      check("fault", 32'(fault), 32'(e_fault));
      check("fault_cause", 32'(fault_cause), 32'(e_cause));
      if (bus.mem_req) req_cycles++;
      if (instr_valid) obs_pc.push_back(pc_out);
    end
  end

  task automatic set_exp(input bit req, input bit valid);
    e_req   = req;
    e_valid = valid;
    e_addr  = {m_pc[31:2], 2'b00};
    e_instr = m_instr;
    e_pc    = m_pc;
    e_fault = (m_status == 3);
    e_cause = m_cause;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset(input bit ack);
    reset         = 1'b1;
    bus.mem_ack   = ack;
    bus.mem_rdata = 32'hDEADBEEF;
    nPc           = $urandom;
    halt          = 1'($urandom);
    set_exp(1'b0, 1'b0);
    tick();
    reset    = 1'b0;
    m_pc     = RESET_PC;
    m_instr  = 32'h00000013;
    m_status = 0;
    m_cause  = 2'b00;
  endtask

  task automatic fetch_cycle(input bit ack);
    bus.mem_ack   = ack;
    bus.mem_rdata = ack ? word(m_pc) : $urandom;
    nPc           = $urandom;
    halt          = 1'($urandom);
    set_exp(1'b1, 1'b0);
    tick();
  endtask

  // One instruction: ack after d wait cycles (d >= TIMEOUT means never), then EXEC with npc/h.
  task automatic fetch_one(input int d, input logic [31:0] npc, input bit h);
    for (int i = 0; i < TIMEOUT; i++) begin
      fetch_cycle(i == d);
      if (i == d) break;
    end
    if (d >= TIMEOUT) begin
      m_status = 3;
      m_cause  = 2'b10;
      return;
    end
    m_instr       = word(m_pc);
    bus.mem_ack   = 1'b1;
    bus.mem_rdata = $urandom;
    nPc           = npc;
    halt          = h;
    set_exp(1'b0, 1'b1);
    tick();
    if (h) m_status = 2;
    else if (npc[1:0] != 2'b00) begin
      m_status = 3;
      m_cause  = 2'b01;
    end else m_pc = npc;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      bus.mem_ack   = 1'($urandom);
      bus.mem_rdata = $urandom;
      nPc           = $urandom;
      halt          = 1'($urandom);
      set_exp(1'b0, 1'b0);
      tick();
    end
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1);
  end

  initial begin
    int          n0;
    logic [31:0] npc;
    do_reset(1'b0);
    chk_en = 1'b1;
    do_reset(1'b1);

    // Zero-wait stream, sequential pc.
    obs_pc.delete();
    for (int k = 0; k < 4; k++) fetch_one(0, m_pc + 32'd4, 1'b0);
    for (int k = 0; k < 4; k++) check("seq_pc", obs_pc[k], 32'(k * 4));

    // Ack delayed 3 cycles: 4 request cycles, acks in EXEC ignored.
    req_cycles = 0;
    fetch_one(3, m_pc + 32'd4, 1'b0);
    check("delay3_req_cycles", 32'(req_cycles), 32'd4);

    // Random delays and aligned targets.
    for (int k = 0; k < 40; k++) begin
      npc = ($urandom_range(0, 3) == 0) ? ($urandom & 32'hFFFFFFFC) : m_pc + 32'd4;
      fetch_one($urandom_range(0, 3), npc, 1'b0);
    end

    // Top-of-memory fetch and wrap.
    fetch_one(0, 32'hFFFFFFFC, 1'b0);
    fetch_one(1, m_pc + 32'd4, 1'b0);
    check("wrap_pc", obs_pc[obs_pc.size() - 1], 32'hFFFFFFFC);
    fetch_one(0, m_pc + 32'd4, 1'b0);
    check("wrapped_pc", obs_pc[obs_pc.size() - 1], 32'h00000000);

    // Halt on the third instruction.
    do_reset(1'b0);
    obs_pc.delete();
    fetch_one(0, 32'd4, 1'b0);
    fetch_one(1, 32'd8, 1'b0);
    fetch_one(2, 32'd12, 1'b1);
    req_cycles = 0;
    idle(20);
    check("halt_pc_out", pc_out, 32'd8);
    check("halt_req_cycles", 32'(req_cycles), 32'd0);
    check("halt_valid_count", 32'(obs_pc.size()), 32'd3);

    // Misaligned target faults; halt in the same EXEC takes priority.
    do_reset(1'b0);
    fetch_one(0, 32'h00000006, 1'b0);
    idle(5);
    check("misalign_fault", 32'(fault), 32'd1);
    check("misalign_cause", 32'(fault_cause), 32'd1);
    do_reset(1'b0);
    fetch_one(0, 32'h00000006, 1'b1);
    idle(5);
    check("halt_prio_fault", 32'(fault), 32'd0);

    // Fetch timeout then restart.
    do_reset(1'b0);
    fetch_one(0, 32'h00000040, 1'b0);
    req_cycles = 0;
    fetch_one(9, 32'd0, 1'b0);
    idle(6);
    check("timeout_req_cycles", 32'(req_cycles), 32'd4);
    check("timeout_cause", 32'(fault_cause), 32'd2);
    do_reset(1'b0);
    fetch_one(0, 32'd4, 1'b0);
    check("restart_pc", obs_pc[obs_pc.size() - 1], RESET_PC);

    // Reset mid-fetch with coincident ack.
    fetch_one(0, 32'h00000080, 1'b0);
    fetch_cycle(1'b0);
    fetch_cycle(1'b0);
    n0 = obs_pc.size();
    do_reset(1'b1);
    check("midrst_nop", instruction, 32'h00000013);
    check("midrst_valid", 32'(instr_valid), 32'd0);
    fetch_one(2, 32'd4, 1'b0);
    check("midrst_next_pc", obs_pc[obs_pc.size() - 1], RESET_PC);
    check("midrst_valid_count", 32'(obs_pc.size()), 32'(n0 + 1));

    // Random episodes including halts, misalignment and timeouts.
    for (int ep = 0; ep < 8; ep++) begin
      do_reset(1'($urandom));
      for (int k = 0; k < 15 && m_status == 0; k++) begin
        npc = ($urandom_range(0, 9) == 0) ? ($urandom | 32'h1) : ($urandom & 32'hFFFFFFFC);
        fetch_one($urandom_range(0, 5), npc, $urandom_range(0, 9) == 0);
      end
      idle(3);
    end

    chk_en = 1'b0;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/fetch_unit.md
FETCH_UNIT -- requirements
Module: fetch_unit

Interface
REQ-001 Parameter RESET_PC, default 32'h00000000, fetch address loaded on reset.
REQ-002 Parameter TIMEOUT, default 255, maximum wait cycles for mem_ack before fault.
REQ-003 clk  input  1  system clock; all state changes on its rising edge.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 nPc  input  32  next-PC computed by the datapath for the instruction currently presented.
REQ-006 halt  input  1  halt indication from the control unit for the instruction currently presented.
REQ-007 mem_rdata  input  32  instruction word from instruction memory.
REQ-008 mem_ack  input  1  memory has valid mem_rdata for the outstanding request.
REQ-009 mem_req  output  1  fetch request to instruction memory.
REQ-010 mem_addr  output  32  word-aligned fetch address.
REQ-011 instruction  output  32  instruction word to the datapath.
REQ-012 instr_valid  output  1  one-cycle strobe: instruction is valid; the datapath commits its state only in this cycle.
REQ-013 pc_out  output  32  address of the instruction presented.
REQ-014 fault  output  1  sticky fault flag.
REQ-015 fault_cause  output  2  00 none, 01 misaligned nPc, 10 fetch timeout.

Function
REQ-016 The FSM SHALL have four states: FETCH, EXEC, HALTED, FAULT.
REQ-017 FETCH: mem_req=1, mem_addr=pc; on a rising edge with mem_ack=1, the block SHALL latch mem_rdata into instruction, set instr_valid=1, and go to EXEC.
REQ-018 FETCH without mem_ack: the wait counter SHALL increment; when it equals TIMEOUT, the block SHALL go to FAULT with fault_cause=10 and mem_req=0.
REQ-019 mem_ack SHALL be ignored in every state except FETCH.
REQ-020 EXEC lasts exactly one cycle: instr_valid=1, mem_req=0, and pc_out = the address of the latched instruction.
REQ-021 EXEC with halt=1: next state SHALL be HALTED; pc SHALL be unchanged; halt SHALL take priority over a misaligned nPc.
REQ-022 EXEC with halt=0 and nPc[1:0]!=00: next state SHALL be FAULT with fault_cause=01; pc SHALL be unchanged.
REQ-023 EXEC otherwise: pc <= nPc, wait counter <= 0, next state FETCH.
REQ-024 Minimum throughput SHALL be one instruction per 2 cycles (ack on the first FETCH cycle); latency from mem_req rising to instr_valid SHALL be (ack wait cycles + 1).
REQ-025 Outside EXEC: instr_valid=0 and instruction SHALL hold its last latched value.
REQ-026 HALTED and FAULT SHALL be absorbing: mem_req=0, instr_valid=0; exit only through reset.
REQ-027 fault SHALL be 1 exactly when the state is FAULT.
REQ-028 mem_addr SHALL always equal pc, with bits [1:0] forced to 00.
REQ-029 pc arithmetic SHALL be 32-bit and wrap modulo 2^32; nPc=32'hFFFFFFFC SHALL be fetched normally.
REQ-030 The wait counter SHALL be 8 bits wide minimum, sized for TIMEOUT, and SHALL saturate and never wrap.

Reset
REQ-031 Reset SHALL set: pc=RESET_PC, state=FETCH, instruction=32'h00000013 (NOP), instr_valid=0, mem_req=0 in the reset cycle, fault=0, fault_cause=00, wait counter=0.
REQ-032 Reset SHALL dominate all other inputs in any state, including mid-fetch; a mem_ack coincident with reset SHALL be discarded.
REQ-033 mem_req SHALL assert in the first cycle after reset deasserts.

Verification
REQ-034 Zero-wait memory, ack every FETCH cycle, nPc=pc+4 -> instr_valid on every 2nd cycle; pc_out sequence 0,4,8,12; instruction matches memory contents.
REQ-035 Ack delayed 3 cycles -> mem_req high for 4 cycles, instr_valid 1 cycle later; early acks while in EXEC are ignored.
REQ-036 Halt on the third instruction -> HALTED; mem_req stays 0 for 20 cycles; pc_out=8; no further instr_valid.
REQ-037 nPc=32'h00000006 in EXEC -> fault=1, fault_cause=01, mem_req=0; with halt=1 in the same EXEC -> HALTED, fault=0.
REQ-038 No ack with TIMEOUT=4 -> fault_cause=10 after 4 wait cycles; reset then restarts a fetch at RESET_PC.
REQ-039 Reset asserted in the middle of a FETCH, together with mem_ack -> instr_valid stays 0, instruction=32'h00000013, and the next fetch is at RESET_PC.
